axi_rd_arbiter: RTL and testbench

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 31 +++
 rtl/axi_rd_arbiter.sv | 124 ++++++++++++
 tb/tb_axi_rd_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and field layout for the AXI read arbiter.
// AR payload is {addr, len, size, burst}; R payload is {data, resp, last}.
package axi_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam int AR_BURST_LSB = 0;
  localparam int AR_SIZE_LSB  = AR_BURST_LSB + 2;
  localparam int AR_LEN_LSB   = AR_SIZE_LSB + 3;
  localparam int AR_ADDR_LSB  = AR_LEN_LSB + 8;

  localparam int R_LAST_BIT   = 0;
  localparam int R_RESP_LSB   = R_LAST_BIT + 1;
  localparam int R_DATA_LSB   = R_RESP_LSB + 2;

  localparam int MODE_RR      = 0;
  localparam int MODE_FIXED   = 1;
endpackage

// File: rtl/rr_pick.sv
// Combinational one-hot picker: first requester found searching upward from
// base with wrap, or from index 0 when mode selects fixed priority.
module rr_pick #(
  parameter int NM = 2,
  parameter int PW = 1
) (
  input  logic [NM-1:0] req,
  input  logic [PW-1:0] base,
  input  logic          mode,
  output logic [NM-1:0] pick
);
  logic [PW-1:0] eff_base;
  logic          found;
  int            idx;

  always_comb begin
    pick     = '0;
    found    = 1'b0;
    idx      = 0;
    eff_base = mode ? '0 : base;
    for (int k = 0; k < NM; k++) begin
      idx = (int'(eff_base) + k) % NM;
      for (int j = 0; j < NM; j++) begin
        if (!found && (j == idx) && req[j]) begin
          pick[j] = 1'b1;
          found   = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/axi_rd_arbiter.sv
// N-master to one-slave AXI read arbiter, one transaction in flight at a time.
// Grant is registered in IDLE and held until the R beat carrying last.
module axi_rd_arbiter import axi_arb_pkg::*; #(
  parameter  int NM   = 2,
  parameter  int AW   = 32,
  parameter  int DW   = 64,
  parameter  int MODE = 0,
  localparam int ARP  = AW + AR_ADDR_LSB,
  localparam int RP   = DW + R_DATA_LSB
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NM-1:0]     m_arvalid,
  output logic [NM-1:0]     m_arready,
  input  logic [NM*ARP-1:0] m_ar_pld,
  output logic [NM-1:0]     m_rvalid,
  input  logic [NM-1:0]     m_rready,
  output logic [RP-1:0]     m_r_pld,
  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ARP-1:0]    s_ar_pld,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [RP-1:0]     s_r_pld,
  output logic [NM-1:0]     grant,
  output logic              len_err
);
  localparam int   PW    = $clog2(NM);
  localparam logic FIXED = (MODE == MODE_FIXED);

  state_t        state, state_nx;
  logic [NM-1:0] pick;
  logic [PW-1:0] ptr, gidx;
  logic [7:0]    cnt, ar_len;
  logic          ar_hs, r_hs, r_last;

  rr_pick #(.NM(NM), .PW(PW)) u_pick (
    .req  (m_arvalid),
    .base (ptr),
    .mode (FIXED),
    .pick (pick)
  );

  always_comb begin
    s_ar_pld = '0;
    gidx     = '0;
    for (int i = 0; i < NM; i++) begin
      if (grant[i]) begin
        s_ar_pld = m_ar_pld[i*ARP +: ARP];
        gidx     = PW'(i);
      end
    end
  end

  assign ar_len  = s_ar_pld[AR_LEN_LSB +: 8];
  assign r_last  = s_r_pld[R_LAST_BIT];
  assign m_r_pld = s_r_pld;
  assign ar_hs   = s_arvalid & s_arready;
  assign r_hs    = s_rvalid & s_rready;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (|m_arvalid)     state_nx = ST_ADDR;
      ST_ADDR: if (ar_hs)          state_nx = ST_DATA;
      ST_DATA: if (r_hs && r_last) state_nx = ST_IDLE;
      default:                     state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    m_arready = '0;
    m_rvalid  = '0;
    case (state)
      ST_ADDR: begin
        s_arvalid = 1'b1;
        m_arready = grant & {NM{s_arready}};
      end
      ST_DATA: begin
        m_rvalid = grant & {NM{s_rvalid}};
        s_rready = |(grant & m_rready);
      end
      default: ;
    endcase
  end

  // Beat accounting: the counter is checked against last, but last alone ends the burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant   <= '0;
      ptr     <= '0;
      cnt     <= '0;
      len_err <= 1'b0;
    end else begin
      len_err <= 1'b0;
      case (state)
        ST_IDLE: if (|m_arvalid) grant <= pick;
        ST_ADDR: if (ar_hs) cnt <= ar_len;
        ST_DATA: if (r_hs) begin
          cnt     <= cnt - 8'd1;
          len_err <= (r_last && (cnt != 8'd0)) || (!r_last && (cnt == 8'd0));
          if (r_last) begin
            grant <= '0;
            ptr   <= (gidx == PW'(NM-1)) ? '0 : gidx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NM; i++) begin : g_hold
    a_ar_hold: assert property (@(posedge clk) disable iff (rst)
      (m_arvalid[i] && !m_arready[i]) |=>
        (m_arvalid[i] && $stable(m_ar_pld[i*ARP +: ARP])));
  end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench: a round-robin instance with a scripted slave, plus a
// fixed-priority instance with masters 1 and 3 requesting continuously.
module tb_axi_rd_arbiter;
  localparam int NM = 4, AW = 32, DW = 64, ARP = AW + 13, RP = DW + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NM-1:0]     m_arvalid = '0, m_rready = '1;
  logic [NM-1:0]     m_arready, m_rvalid, grant;
  logic [NM*ARP-1:0] m_ar_pld = '0;
  logic [RP-1:0]     m_r_pld, s_r_pld = '0;
  logic [ARP-1:0]    s_ar_pld;
  logic              s_arvalid, s_arready, s_rvalid = 1'b0, s_rready, len_err;
  assign s_arready = 1'b1;

  axi_rd_arbiter #(.NM(NM), .AW(AW), .DW(DW), .MODE(0)) u_rr (
    .clk(clk), .rst(rst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_ar_pld(m_ar_pld),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_r_pld(m_r_pld),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_ar_pld(s_ar_pld),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_r_pld(s_r_pld),
    .grant(grant), .len_err(len_err)
  );

  logic [NM-1:0]     fx_arvalid, fx_arready, fx_rvalid, fx_rready, fx_grant;
  logic [NM*ARP-1:0] fx_ar_pld;
  logic [RP-1:0]     fx_m_r_pld, fx_s_r_pld;
  logic [ARP-1:0]    fx_s_ar_pld;
  logic              fx_s_arvalid, fx_s_arready, fx_s_rvalid, fx_s_rready, fx_len_err;
  assign fx_arvalid   = 4'b1010;
  assign fx_ar_pld    = {32'hA300, 8'd0, 3'd3, 2'b01, 45'd0, 32'hA100, 8'd0, 3'd3, 2'b01, 45'd0};
  assign fx_rready    = '1;
  assign fx_s_arready = 1'b1;
  assign fx_s_rvalid  = 1'b1;
  assign fx_s_r_pld   = {64'hF00D, 2'b00, 1'b1};

  axi_rd_arbiter #(.NM(NM), .AW(AW), .DW(DW), .MODE(1)) u_fx (
    .clk(clk), .rst(rst),
    .m_arvalid(fx_arvalid), .m_arready(fx_arready), .m_ar_pld(fx_ar_pld),
    .m_rvalid(fx_rvalid), .m_rready(fx_rready), .m_r_pld(fx_m_r_pld),
    .s_arvalid(fx_s_arvalid), .s_arready(fx_s_arready), .s_ar_pld(fx_s_ar_pld),
    .s_rvalid(fx_s_rvalid), .s_rready(fx_s_rready), .s_r_pld(fx_s_r_pld),
    .grant(fx_grant), .len_err(fx_len_err)
  );

  int total = 0, bad = 0, cyc = 0, err_cnt = 0, fx_grants = 0, last_beat_cyc = -100;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {logic [1:0] m; logic [31:0] addr; logic [7:0] len;} ar_exp_t;
  typedef struct packed {logic [1:0] m; logic [63:0] data; logic last;} r_exp_t;
  ar_exp_t exp_ar[$];
  r_exp_t  exp_r[$];

  logic [31:0] pa [NM][8];
  logic [7:0]  pl [NM][8];
  int          ph [NM] = '{default: 0};
  int          pt [NM] = '{default: 0};

  bit rr_toggle = 1'b0, slave_stall = 1'b0;
  int early_last = -1;

  task automatic issue(input int m, input logic [31:0] addr, input logic [7:0] len);
    pa[m][pt[m]] = addr;
    pl[m][pt[m]] = len;
    pt[m]++;
  endtask

  task automatic expect_txn(input int m, input logic [31:0] addr, input logic [7:0] len, input int nbeats);
    exp_ar.push_back('{m: 2'(m), addr: addr, len: len});
    for (int k = 0; k < nbeats; k++)
      exp_r.push_back('{m: 2'(m), data: 64'(addr) + 64'(k), last: (k == nbeats - 1)});
  endtask

  task automatic drain(input string nm, input int budget);
    int n = 0;
    while ((exp_ar.size() != 0 || exp_r.size() != 0 || grant != '0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, n < budget, 1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Master side: present queued requests in order, advance on the AR handshake.
  logic [NM-1:0] drv_hs;
  always @(posedge clk) begin
    drv_hs = m_arvalid & m_arready;
    #1;
    for (int i = 0; i < NM; i++) begin
      if (drv_hs[i]) ph[i]++;
      if (ph[i] < pt[i]) begin
        m_arvalid[i] = 1'b1;
        m_ar_pld[i*ARP +: ARP] = {pa[i][ph[i]], pl[i][ph[i]], 3'd3, 2'b01};
      end else begin
        m_arvalid[i] = 1'b0;
      end
    end
    m_rready = (rr_toggle && cyc[0]) ? '0 : '1;
  end

  // Slave: returns data = addr + beat, last on beat len (or early_last when set).
  logic        sl_active = 1'b0, sl_ar_hs, sl_r_hs, sl_rst;
  logic [31:0] sl_addr = '0, sl_new_addr;
  int          sl_beat = 0, sl_last = 0, sl_new_len;
  always @(posedge clk) begin
    sl_ar_hs    = s_arvalid && s_arready;
    sl_r_hs     = s_rvalid && s_rready;
    sl_rst      = rst;
    sl_new_addr = s_ar_pld[ARP-1 -: AW];
    sl_new_len  = int'(s_ar_pld[12:5]);
    #1;
    if (sl_rst) sl_active = 1'b0;
    else begin
      if (sl_r_hs) begin
        if (sl_beat == sl_last) sl_active = 1'b0;
        else sl_beat++;
      end
      if (sl_ar_hs) begin
        sl_active = 1'b1;
        sl_beat   = 0;
        sl_addr   = sl_new_addr;
        sl_last   = (early_last >= 0) ? early_last : sl_new_len;
      end
    end
    s_rvalid = sl_active && !slave_stall;
    s_r_pld  = {64'(sl_addr) + 64'(sl_beat), 2'b00, sl_active && (sl_beat == sl_last)};
  end

  ar_exp_t       ea;
  r_exp_t        er;
  logic [NM-1:0] rh;
  always @(negedge clk) begin
    if (!rst) begin
      if (s_arvalid && s_arready) begin
        if (exp_ar.size() == 0) begin
          total++; bad++;
          $display("FAIL ar_unexpected: got grant %0h expected no request", grant);
        end else begin
          ea = exp_ar.pop_front();
          chk("ar_grant", grant, 64'(1) << ea.m);
          chk("ar_addr", s_ar_pld[ARP-1 -: AW], ea.addr);
          chk("ar_len", s_ar_pld[12:5], ea.len);
          chk("ar_ready", m_arready, grant);
          chk("ar_gap", (cyc - last_beat_cyc) >= 2, 1);
        end
      end
      if (m_rvalid != '0) chk("r_owner_only", m_rvalid & ~grant, 0);
      rh = m_rvalid & m_rready;
      if (rh != '0) begin
        if (exp_r.size() == 0) begin
          total++; bad++;
          $display("FAIL r_unexpected: got beat to %0h expected none", rh);
        end else begin
          er = exp_r.pop_front();
          chk("r_master", rh, 64'(1) << er.m);
          chk("r_data", m_r_pld[RP-1 -: DW], er.data);
          chk("r_last", m_r_pld[0], er.last);
          if (m_r_pld[0]) last_beat_cyc = cyc;
        end
      end
      if (len_err) err_cnt++;
      if (fx_s_arvalid) begin
        chk("fx_grant", fx_grant, 4'b0010);
        fx_grants++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, err_before;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_s_arvalid", s_arvalid, 0);
    chk("rst_s_rready", s_rready, 0);
    chk("rst_m_arready", m_arready, 0);
    chk("rst_m_rvalid", m_rvalid, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_fx_grant", fx_grant, 0);
    rst = 1'b0;

    // Two simultaneous requests after reset: master 0 first, one-cycle AR latency.
    @(negedge clk);
    expect_txn(0, 32'h1000, 8'd1, 2);
    expect_txn(1, 32'h2000, 8'd0, 1);
    issue(0, 32'h1000, 8'd1);
    issue(1, 32'h2000, 8'd0);
    n = 0;
    while (m_arvalid == '0 && n < 20) begin @(negedge clk); n++; end
    chk("lat_req_seen", m_arvalid, 4'b0011);
    @(negedge clk);
    chk("lat_s_arvalid", s_arvalid, 1);
    chk("lat_first_grant", grant, 4'b0001);
    drain("a_drain", 200);

    // All four masters request continuously from ptr = 0.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int m = 0; m < NM; m++)
        expect_txn(m, 32'h3000 + 32'(m) * 32'h100 + 32'(r) * 32'h10, 8'd0, 1);
    for (int m = 0; m < NM; m++) begin
      issue(m, 32'h3000 + 32'(m) * 32'h100, 8'd0);
      issue(m, 32'h3010 + 32'(m) * 32'h100, 8'd0);
    end
    drain("b_drain", 400);

    // Four-beat burst with R backpressure.
    @(negedge clk);
    rr_toggle = 1'b1;
    err_before = err_cnt;
    expect_txn(2, 32'h4000, 8'd3, 4);
    issue(2, 32'h4000, 8'd3);
    drain("c_drain", 200);
    repeat (2) @(negedge clk);
    chk("c_no_len_err", err_cnt - err_before, 0);
    rr_toggle = 1'b0;

    // Early last on the third beat of a len=3 burst.
    early_last = 2;
    err_before = err_cnt;
    expect_txn(1, 32'h5000, 8'd3, 3);
    issue(1, 32'h5000, 8'd3);
    drain("d_drain", 200);
    repeat (2) @(negedge clk);
    chk("d_len_err_pulses", err_cnt - err_before, 1);
    early_last = -1;

    // Reset while in DATA.
    slave_stall = 1'b1;
    exp_ar.push_back('{m: 2'd3, addr: 32'h6000, len: 8'd2});
    issue(3, 32'h6000, 8'd2);
    n = 0;
    while (exp_ar.size() != 0 && n < 50) begin @(negedge clk); n++; end
    chk("e_ar_seen", n < 50, 1);
    @(negedge clk);
    chk("e_data_grant", grant, 4'b1000);
    chk("e_data_rready", s_rready, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("e_rst_grant", grant, 0);
    chk("e_rst_s_arvalid", s_arvalid, 0);
    chk("e_rst_s_rready", s_rready, 0);
    chk("e_rst_m_rvalid", m_rvalid, 0);
    chk("e_rst_m_arready", m_arready, 0);
    chk("e_rst_fx_s_arvalid", fx_s_arvalid, 0);
    slave_stall = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    expect_txn(0, 32'h7000, 8'd0, 1);
    issue(0, 32'h7000, 8'd0);
    drain("e_post_drain", 200);

    chk("fx_grant_count", fx_grants > 5, 1);
    chk("sb_ar_empty", exp_ar.size(), 0);
    chk("sb_r_empty", exp_r.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
